uart_rx_frame_fsm: RTL and testbench

//   Frame decoder for the UART receiver. Sits directly downstream of the input

---
 rtl/uart_rx_frame_fsm.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frame_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_fsm.sv
// UART receive frame decoder: validates the start bit, samples data/parity/stop
// at mid-bit on the 16x tick grid and hands each byte out on a valid/ready port.
module uart_rx_frame_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rx_filtered,
    input  logic                 falling_edge,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic [3:0]           tick_cnt, tick_cnt_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 perr, perr_nxt;
    logic                 ferr, ferr_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic                 frame_done, frame_done_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt, framing_err_nxt, parity_err_nxt, overrun_err_nxt;
    logic                 mid_bit;

    // Start bit is checked at tick 7; every later bit is 16 ticks on, at tick 15.
    assign mid_bit = tick_16x && (tick_cnt == 4'd15);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick_cnt    <= 4'd0;
            bit_cnt     <= 4'd0;
            shift       <= '0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
            stop_cnt    <= 1'b0;
            frame_done  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            perr        <= perr_nxt;
            ferr        <= ferr_nxt;
            stop_cnt    <= stop_cnt_nxt;
            frame_done  <= frame_done_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            framing_err <= framing_err_nxt;
            parity_err  <= parity_err_nxt;
            overrun_err <= overrun_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_16x ? tick_cnt + 4'd1 : tick_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        perr_nxt       = perr;
        ferr_nxt       = ferr;
        stop_cnt_nxt   = stop_cnt;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (falling_edge) begin
                    state_nxt    = START;
                    tick_cnt_nxt = 4'd0;
                end
            end
            START: begin
                if (tick_16x && (tick_cnt == 4'd7)) begin
                    if (!rx_filtered) begin
                        state_nxt    = DATA;
                        tick_cnt_nxt = 4'd0;
                        bit_cnt_nxt  = 4'd0;
                        perr_nxt     = 1'b0;
                        ferr_nxt     = 1'b0;
                        stop_cnt_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shift_nxt   = {rx_filtered, shift[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_BITS - 1))
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    perr_nxt  = (^{shift, rx_filtered}) ^ (PARITY_ODD != 0);
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at the mid-stop sample lets the next start edge resync early.
                if (mid_bit) begin
                    ferr_nxt = ferr | ~rx_filtered;
                    if ((STOP_BITS < 2) || stop_cnt) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A frame finishing while the previous byte is unclaimed is dropped, not queued.
    always_comb begin
        rx_data_nxt     = rx_data;
        rx_valid_nxt    = rx_valid;
        framing_err_nxt = framing_err;
        parity_err_nxt  = parity_err;
        overrun_err_nxt = 1'b0;

        if (rx_valid && rx_ready) begin
            rx_valid_nxt    = 1'b0;
            framing_err_nxt = 1'b0;
            parity_err_nxt  = 1'b0;
        end

        if (frame_done) begin
            if (!rx_valid || rx_ready) begin
                rx_data_nxt     = shift;
                rx_valid_nxt    = 1'b1;
                framing_err_nxt = ferr;
                parity_err_nxt  = perr;
            end else begin
                overrun_err_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Scoreboard bench for uart_rx_frame_fsm: one 8N1 and one 8E1 instance, each
// fed its own serial line; expected bytes are queued as frames are driven.
module tb_uart_rx_frame_fsm;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tdiv = 2'd0;
    logic       tick_16x;
    int         tick_total = 0;

    logic line_n = 1'b1, line_p = 1'b1, prev_n = 1'b1, prev_p = 1'b1;
    logic fe_n, fe_p;
    logic ready_n = 1'b1, ready_p = 1'b1;

    logic [7:0] data_n, data_p;
    logic valid_n, valid_p, ferr_n, ferr_p, perr_n, perr_p;
    logic ovr_n, ovr_p, busy_n, busy_p;

    int   checks = 0, errors = 0;
    exp_t q_n[$], q_p[$];
    exp_t got_n, got_p;
    int   ovr_exp_n = 0, ovr_exp_p = 0, ovr_seen_n = 0, ovr_seen_p = 0;

    always #5 clk = ~clk;

    assign tick_16x = (tdiv == 2'd3);
    always @(posedge clk) begin
        tdiv <= tdiv + 2'd1;
        if (tick_16x) tick_total <= tick_total + 1;
        prev_n <= line_n;
        prev_p <= line_p;
    end

    // Stands in for the upstream filter's 1->0 strobe.
    assign fe_n = prev_n & ~line_n;
    assign fe_p = prev_p & ~line_p;

    uart_rx_frame_fsm #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_filtered(line_n),
        .falling_edge(fe_n), .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
        .framing_err(ferr_n), .parity_err(perr_n), .overrun_err(ovr_n), .busy(busy_n)
    );

    uart_rx_frame_fsm #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_filtered(line_p),
        .falling_edge(fe_p), .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
        .framing_err(ferr_p), .parity_err(perr_p), .overrun_err(ovr_p), .busy(busy_p)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        int t0;
        t0 = tick_total;
        while (tick_total - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBit(input bit sel, input logic b, input int n);
        if (sel) line_p = b;
        else     line_n = b;
        waitTicks(n);
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic par,
                                 input logic stop, input bit drop);
        exp_t e;
        e.data = data;
        e.ferr = ~stop;
        e.perr = sel ? ((^data) ^ par) : 1'b0;
        if (drop) begin
            if (sel) ovr_exp_p++;
            else     ovr_exp_n++;
        end else if (sel) begin
            q_p.push_back(e);
        end else begin
            q_n.push_back(e);
        end
        driveBit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) driveBit(sel, data[i], 16);
        if (sel) driveBit(sel, par, 16);
        driveBit(sel, stop, 16);
        driveBit(sel, 1'b1, 8);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr_n) ovr_seen_n++;
            if (ovr_p) ovr_seen_p++;
            if (valid_n && ready_n) begin
                if (q_n.size() == 0) begin
                    checkOutput("n_unexpected_byte", {24'd0, data_n}, 32'hFFFF_FFFF);
                end else begin
                    got_n = q_n.pop_front();
                    checkOutput("n_data", data_n, got_n.data);
                    checkOutput("n_framing_err", ferr_n, got_n.ferr);
                    checkOutput("n_parity_err", perr_n, got_n.perr);
                end
            end
            if (valid_p && ready_p) begin
                if (q_p.size() == 0) begin
                    checkOutput("p_unexpected_byte", {24'd0, data_p}, 32'hFFFF_FFFF);
                end else begin
                    got_p = q_p.pop_front();
                    checkOutput("p_data", data_p, got_p.data);
                    checkOutput("p_framing_err", ferr_p, got_p.ferr);
                    checkOutput("p_parity_err", perr_p, got_p.perr);
                end
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", valid_n, 1'b0);
        checkOutput("reset_data", data_n, 8'h00);
        checkOutput("reset_flags", {ferr_n, perr_n, ovr_n}, 3'b000);
        checkOutput("reset_busy", busy_n, 1'b0);
        checkOutput("reset_p_valid", valid_p, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(1'b0, 8'h55, 1'b0, 1'b1, 1'b0);

        // Start glitch: low for 4 ticks only.
        line_n = 1'b0;
        waitTicks(4);
        checkOutput("glitch_busy", busy_n, 1'b1);
        line_n = 1'b1;
        waitTicks(8);
        checkOutput("glitch_idle", busy_n, 1'b0);
        checkOutput("glitch_valid", valid_n, 1'b0);

        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);

        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h3D, 1'b0, 1'b1, 1'b0);

        // Overrun: consumer stalled across two frames.
        ready_n = 1'b0;
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
        checkOutput("ovr_hold_data", data_n, 8'h11);
        checkOutput("ovr_hold_valid", valid_n, 1'b1);
        ready_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ovr_valid_clear", valid_n, 1'b0);

        // Reset in the middle of the data bits of 0xF0.
        line_n = 1'b0;
        waitTicks(16);
        waitTicks(24);
        checkOutput("mid_busy", busy_n, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mid_rst_data", data_n, 8'h00);
        checkOutput("mid_rst_valid", valid_n, 1'b0);
        checkOutput("mid_rst_busy", busy_n, 1'b0);
        line_n = 1'b1;
        waitTicks(16);
        applyStimulus(1'b0, 8'h0F, 1'b0, 1'b1, 1'b0);

        guard = 0;
        while ((q_n.size() != 0 || q_p.size() != 0) && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checkOutput("drain_n", q_n.size(), 0);
        checkOutput("drain_p", q_p.size(), 0);
        checkOutput("overrun_n", ovr_seen_n, ovr_exp_n);
        checkOutput("overrun_p", ovr_seen_p, ovr_exp_p);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
